// File: rtl/time_display_driver_pkg.sv
// Shared definitions for the time display driver: time bus layout, FSM
// state encoding and the active-low 7-segment table.
package time_display_driver_pkg;

   // Packed time/date bus field positions
   localparam int unsigned F2_MSB = 16;
   localparam int unsigned F2_LSB = 12;
   localparam int unsigned F1_MSB = 11;
   localparam int unsigned F1_LSB = 6;
   localparam int unsigned F0_MSB = 5;
   localparam int unsigned F0_LSB = 0;

   localparam int unsigned TIME_W     = 17;
   localparam int unsigned FIELD_W    = 6;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned MAX_MS     = 59;

   // Latched copy of the incoming bus
   typedef struct packed {
      logic [F2_MSB-F2_LSB:0] f2;
      logic [F1_MSB-F1_LSB:0] f1;
      logic [F0_MSB-F0_LSB:0] f0;
   } time_bus_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_e;

   localparam logic [SEG_W-1:0] BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element
   localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Non-decimal digit values render as blank
   function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
      logic [SEG_W-1:0] s;
      s = BLANK;
      if (digit <= 4'd9) s = SEG_TABLE[digit];
      return s;
   endfunction

endpackage

// File: rtl/time_display_driver_bin6_to_bcd.sv
// Iterative 6-bit binary to two-digit BCD converter (shift-add-3).
// Ports: clk, rst (sync, active-low), start (loads bin and performs the
// first shift), bin[5:0], tens/ones (valid while ready=1), ready (one-cycle
// pulse after the sixth shift).
module time_display_driver_bin6_to_bcd
   import time_display_driver_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FIELD_W-1:0] bin,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               ready
);

   logic [FIELD_W-1:0]   bin_q;
   logic [2*DIGIT_W-1:0] bcd_q;
   logic [2*DIGIT_W-1:0] bcd_adj;
   logic [2:0]           cnt_q;
   logic                 ready_q;

   // Add 3 to any nibble >= 5 ahead of the next shift
   always_comb begin
      bcd_adj = bcd_q;
      if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
      if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
   end

   // Start performs shift 1 (BCD is zero, so no adjust); cnt_q counts shifts done
   always_ff @(posedge clk) begin
      if (!rst) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (start) begin
            bcd_q <= {7'd0, bin[FIELD_W-1]};
            bin_q <= {bin[FIELD_W-2:0], 1'b0};
            cnt_q <= 3'd1;
         end else if (cnt_q != 3'd0) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            if (cnt_q == 3'd5) begin
               cnt_q   <= 3'd0;
               ready_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 3'd1;
            end
         end
      end
   end

   assign tens  = bcd_q[7:4];
   assign ones  = bcd_q[3:0];
   assign ready = ready_q;

endmodule

// File: rtl/time_display_driver.sv
// Accepts a packed {f2,f1,f0} time word, converts each field to two BCD
// digits through one shared sequential converter, and scans the six digits
// onto a multiplexed common-anode 7-segment display.
// Ports: clk, rst (sync, active-low), in_time[16:0], in_valid, disp_en;
// busy, done (commit pulse), range_err, seg[6:0], dp, an[5:0] (all active-low
// display outputs, an[5] = f2 tens ... an[0] = f0 ones).
module time_display_driver
   import time_display_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4,
   parameter bit          DP_EN    = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TIME_W-1:0]     in_time,
   input  logic                  in_valid,
   input  logic                  disp_en,
   output logic                  busy,
   output logic                  done,
   output logic                  range_err,
   output logic [SEG_W-1:0]      seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   conv_state_e                            state_q;
   time_bus_t                              time_q;
   logic [1:0]                             field_sel_q;
   logic [2:0]                             cnt_q;
   logic [4*DIGIT_W-1:0]                   stage_q;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     digits_q;
   logic                                   busy_q;
   logic                                   done_q;
   logic                                   range_err_q;

   logic [FIELD_W-1:0] conv_bin;
   logic               conv_start;
   logic [DIGIT_W-1:0] conv_tens;
   logic [DIGIT_W-1:0] conv_ones;
   logic               conv_ready;

   // Field currently routed to the converter
   always_comb begin
      conv_bin = time_q.f0;
      case (field_sel_q)
         2'd2:    conv_bin = FIELD_W'(time_q.f2);
         2'd1:    conv_bin = time_q.f1;
         default: conv_bin = time_q.f0;
      endcase
   end

   // Launch the converter at the first cycle of each 6-shift field slot
   assign conv_start = (state_q == ST_CONV) && (cnt_q == 3'd0);

   time_display_driver_bin6_to_bcd u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (conv_bin),
      .tens  (conv_tens),
      .ones  (conv_ones),
      .ready (conv_ready)
   );

   // Conversion sequencer; finished fields queue in stage_q so the six
   // displayed digits change only at commit
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         time_q      <= '0;
         field_sel_q <= 2'd0;
         cnt_q       <= 3'd0;
         stage_q     <= '0;
         digits_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (conv_ready) stage_q <= {stage_q[2*DIGIT_W-1:0], conv_tens, conv_ones};
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  time_q.f2   <= in_time[F2_MSB:F2_LSB];
                  time_q.f1   <= in_time[F1_MSB:F1_LSB];
                  time_q.f0   <= in_time[F0_MSB:F0_LSB];
                  field_sel_q <= 2'd2;
                  cnt_q       <= 3'd0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (cnt_q == 3'd5) begin
                  cnt_q <= 3'd0;
                  if (field_sel_q == 2'd0) state_q <= ST_COMMIT;
                  else                     field_sel_q <= field_sel_q - 2'd1;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            ST_COMMIT: begin
               // f0 result is still on the converter outputs this cycle
               digits_q    <= {stage_q, conv_tens, conv_ones};
               range_err_q <= (time_q.f1 > 6'(MAX_MS)) || (time_q.f0 > 6'(MAX_MS));
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign range_err = range_err_q;

   // Scanner: free-running divider and digit index
   logic [DIV_W-1:0]      div_q, div_d;
   logic [2:0]            idx_q, idx_d;
   logic [SEG_W-1:0]      seg_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic                  dp_q;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
         div_d = '0;
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
   end

   // Outputs follow the next index so they change on the same edge as it
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q <= '0;
         idx_q <= 3'd0;
         seg_q <= BLANK;
         an_q  <= '1;
         dp_q  <= 1'b1;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         if (disp_en) begin
            an_q  <= ~(6'b1 << idx_d);
            seg_q <= seg_encode(digits_q[idx_d]);
            dp_q  <= !(DP_EN && ((idx_d == 3'd2) || (idx_d == 3'd4)));
         end else begin
            an_q  <= '1;
            seg_q <= BLANK;
            dp_q  <= 1'b1;
         end
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Scoreboard bench for time_display_driver: loads push expected commits,
// a monitor pops them on each done pulse; display scans are checked
// against a hand-written segment table.
module tb_time_display_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] in_time;
   logic        in_valid;
   logic        disp_en;
   logic        busy, done, range_err, dp;
   logic [6:0]  seg;
   logic [5:0]  an;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic re;
      int   due;
   } exp_t;
   exp_t sb_q[$];

   time_display_driver #(.SCAN_DIV(4), .DP_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_time   (in_time),
      .in_valid  (in_valid),
      .disp_en   (disp_en),
      .busy      (busy),
      .done      (done),
      .range_err (range_err),
      .seg       (seg),
      .dp        (dp),
      .an        (an)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [5:0] exp_an(input int i);
      logic [5:0] v;
      v = 6'h3F;
      v[i] = 1'b0;
      return v;
   endfunction

   // Monitor: every done pulse must match the oldest expected commit
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("done_latency", 32'(cyc), 32'(e.due));
            chk("range_err", 32'(range_err), 32'(e.re));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge
   task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                       input bit commit, input logic re);
      exp_t e;
      in_time  = {h, m, s};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (commit) begin
         e.re  = re;
         e.due = cyc + 19;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_sb();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("commit_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic check_display(input string tag, input logic [23:0] d);
      int         idx;
      logic [5:0] seen;
      logic [3:0] dg;
      seen = '0;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         idx = -1;
         for (int i = 0; i < 6; i++) if (an == exp_an(i)) idx = i;
         if (idx < 0) begin
            chk({tag, "_an_onehot"}, 32'(an), 32'h3E);
         end else begin
            dg = d[4*idx +: 4];
            chk({tag, "_seg"}, 32'(seg), 32'(seg_ref(dg)));
            chk({tag, "_dp"}, 32'(dp), (idx == 2 || idx == 4) ? 32'd0 : 32'd1);
            seen[idx] = 1'b1;
         end
      end
      chk({tag, "_all_digits"}, 32'(seen), 32'h3F);
   endtask

   initial begin
      int         k;
      bit         found;
      logic [5:0] prev_an;

      rst = 1'b0; in_valid = 1'b0; in_time = '0; disp_en = 1'b1;

      // 1: reset state, then all-zero display
      @(negedge clk);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_range_err", 32'(range_err), 32'd0);
      @(negedge clk);
      chk("rst_an_2", 32'(an), 32'h3F);
      rst = 1'b1;
      check_display("t1", 24'h000000);

      // 2+3: 12:34:56 with an ignored load while busy
      load(5'd12, 6'd34, 6'd56, 1'b1, 1'b0);
      chk("busy_after_accept", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      in_time  = {5'd23, 6'd59, 6'd59};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_mid_conv", 32'(busy), 32'd1);
      wait_sb();
      check_display("t2", 24'h123456);

      // 4: out-of-range minutes/seconds, then a clean load clears range_err
      load(5'd31, 6'd60, 6'd63, 1'b1, 1'b1);
      wait_sb();
      check_display("t4", 24'h316063);
      load(5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
      wait_sb();
      check_display("t4b", 24'h000000);

      // Load accepted during the done cycle
      load(5'd1, 6'd2, 6'd3, 1'b1, 1'b0);
      repeat (19) @(negedge clk);
      load(5'd4, 6'd5, 6'd6, 1'b1, 1'b0);
      wait_sb();
      check_display("t_b2b", 24'h040506);

      // 5: reset mid-conversion aborts it
      load(5'd12, 6'd34, 6'd56, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_an", 32'(an), 32'h3F);
      rst = 1'b1;
      check_display("t5", 24'h000000);
      chk("abort_range_err", 32'(range_err), 32'd0);

      // 6: scan timing, blanking and resume
      prev_an = an;
      found   = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (an != prev_an) found = 1'b1;
         else prev_an = an;
      end
      chk("scan_transition_found", 32'(found), 32'd1);
      k = 0;
      for (int i = 0; i < 6; i++) if (an == exp_an(i)) k = i;
      for (int n = 0; n < 48; n++) begin
         if (n > 0) @(negedge clk);
         chk("scan_seq", 32'(an), 32'(exp_an((k + n / 4) % 6)));
      end
      disp_en = 1'b0;
      @(negedge clk);
      chk("blank_an", 32'(an), 32'h3F);
      chk("blank_seg", 32'(seg), 32'h7F);
      chk("blank_dp", 32'(dp), 32'd1);
      repeat (10) @(negedge clk);
      disp_en = 1'b1;
      @(negedge clk);
      chk("resume_an", 32'(an), 32'(exp_an((k + 59 / 4) % 6)));
      chk("resume_seg", 32'(seg), 32'h40);

      repeat (25) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
